// File: rtl/rs_ooo_generic.sv
// rs_ooo_generic: parametrised reservation station with a collapsing age queue.
// Buffers renamed micro-ops from dispatch, snoops CDB_PORTS wakeup ports and
// issues one ready entry per cycle to its functional unit.
//
// Optional feature macro: RS_OOO_ISSUE_EN
//   defined   -> oldest ready slot anywhere in the queue issues
//   undefined -> only slot 0 may issue (strict in-order)
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   valid_in, instr     dispatch request and micro-op payload
//   ready_in            station can accept an entry (registered count < DEPTH)
//   fu_rdy              functional unit accepts an issue this cycle
//   valid_out, data_out selected issuable entry (data_out all-zero when idle)
//   cdb_tag, cdb_valid  CDB wakeup broadcast ports
//   flush               discard every entry
//   count               occupied entries

package types_pkg;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned ROB_W  = 5;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [6:0]        opcode;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              pr1_ready;
    logic [PREG_W-1:0] pr2;
    logic              pr2_ready;
    logic [ROB_W-1:0]  rob_index;
    logic [XLEN-1:0]   imm;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } dispatch_pipeline_data;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [6:0]        opcode;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] pr1;
    logic              ps1_ready;
    logic [PREG_W-1:0] pr2;
    logic              ps2_ready;
    logic [ROB_W-1:0]  rob_index;
    logic [XLEN-1:0]   imm;
    logic [2:0]        func3;
    logic [6:0]        func7;
  } rs_data;
endpackage

module rs_ooo_generic #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned CDB_PORTS = 3,
  parameter int unsigned PREG_W    = 7
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_in,
  input  types_pkg::dispatch_pipeline_data     instr,
  output logic                                 ready_in,
  input  logic                                 fu_rdy,
  output logic                                 valid_out,
  output types_pkg::rs_data                    data_out,
  input  logic [CDB_PORTS-1:0][PREG_W-1:0]     cdb_tag,
  input  logic [CDB_PORTS-1:0]                 cdb_valid,
  input  logic                                 flush,
  output logic [$clog2(DEPTH+1)-1:0]           count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  types_pkg::rs_data slot_q   [DEPTH];
  types_pkg::rs_data slot_n   [DEPTH];
  types_pkg::rs_data slot_ext [DEPTH+1];  // slot_q plus an empty entry above the top

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] wr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             do_issue;
  logic             do_dispatch;

  // True when any valid CDB port broadcasts the given tag this cycle.
  function automatic logic cdb_hit(input logic [PREG_W-1:0] tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB_PORTS; k++) begin
      if (cdb_valid[k] && (cdb_tag[k] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  assign ready_in    = (count_q < CNT_W'(DEPTH));
  assign count       = count_q;
  assign do_issue    = valid_out && fu_rdy;
  assign do_dispatch = valid_in && ready_in;

  // Select from registered state only: oldest ready slot, or slot 0 in-order.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
`ifdef RS_OOO_ISSUE_EN
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && slot_q[i].ps1_ready && slot_q[i].ps2_ready) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
`else
    if ((count_q != '0) && slot_q[0].ps1_ready && slot_q[0].ps2_ready) begin
      sel_found = 1'b1;
    end
`endif
    valid_out = sel_found;
    data_out  = sel_found ? slot_q[sel_idx] : '0;
  end

  // Next state: collapse above the issued slot, apply wakeups, append dispatch.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot_ext[i] = slot_q[i];
    slot_ext[DEPTH] = '0;
    count_n = count_q + CNT_W'(do_dispatch) - CNT_W'(do_issue);
    wr_ptr  = count_q - CNT_W'(do_issue);

    for (int i = 0; i < DEPTH; i++) begin
      if (do_issue && (IDX_W'(i) >= sel_idx)) slot_n[i] = slot_ext[i+1];
      else                                    slot_n[i] = slot_ext[i];
      if (cdb_hit(slot_n[i].pr1)) slot_n[i].ps1_ready = 1'b1;
      if (cdb_hit(slot_n[i].pr2)) slot_n[i].ps2_ready = 1'b1;
    end

    if (do_dispatch) begin
      slot_n[IDX_W'(wr_ptr)].pc        = instr.pc;
      slot_n[IDX_W'(wr_ptr)].opcode    = instr.opcode;
      slot_n[IDX_W'(wr_ptr)].prd       = instr.prd;
      slot_n[IDX_W'(wr_ptr)].pr1       = instr.pr1;
      slot_n[IDX_W'(wr_ptr)].ps1_ready = instr.pr1_ready || cdb_hit(instr.pr1);
      slot_n[IDX_W'(wr_ptr)].pr2       = instr.pr2;
      slot_n[IDX_W'(wr_ptr)].ps2_ready = instr.pr2_ready || cdb_hit(instr.pr2);
      slot_n[IDX_W'(wr_ptr)].rob_index = instr.rob_index;
      slot_n[IDX_W'(wr_ptr)].imm       = instr.imm;
      slot_n[IDX_W'(wr_ptr)].func3     = instr.func3;
      slot_n[IDX_W'(wr_ptr)].func7     = instr.func7;
    end
  end

  // State register; reset and flush both empty the station.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_n[i];
    end
  end

endmodule

// File: tb/tb_rs_ooo_generic.sv
module tb_rs_ooo_generic;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned CDB_PORTS = 3;
  localparam int unsigned PREG_W    = 7;

  logic                              clk = 1'b0;
  logic                              reset;
  logic                              valid_in;
  types_pkg::dispatch_pipeline_data  instr;
  logic                              ready_in;
  logic                              fu_rdy;
  logic                              valid_out;
  types_pkg::rs_data                 data_out;
  logic [CDB_PORTS-1:0][PREG_W-1:0]  cdb_tag;
  logic [CDB_PORTS-1:0]              cdb_valid;
  logic                              flush;
  logic [$clog2(DEPTH+1)-1:0]        count;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb [$];

  rs_ooo_generic #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS), .PREG_W(PREG_W)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .instr(instr),
    .ready_in(ready_in), .fu_rdy(fu_rdy), .valid_out(valid_out),
    .data_out(data_out), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid),
    .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Score any issue taking place at the coming edge, then advance one cycle.
  task automatic tick();
    logic [31:0] e;
    if (valid_out && fu_rdy && !flush && !reset) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_issue", data_out.pc, 32'hDEAD_DEAD);
      end else begin
        e = sb.pop_front();
        chk("issue_pc", data_out.pc, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [6:0] p1, input logic r1,
                           input logic [6:0] p2, input logic r2);
    instr           = '0;
    instr.pc        = pc;
    instr.pr1       = p1;
    instr.pr1_ready = r1;
    instr.pr2       = p2;
    instr.pr2_ready = r2;
    instr.prd       = 7'd99;
    instr.rob_index = pc[4:0];
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [6:0] p1, input logic r1,
                          input logic [6:0] p2, input logic r2);
    set_instr(pc, p1, r1, p2, r2);
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic drain(input int n);
    fu_rdy = 1'b1;
    for (int i = 0; i < n; i++) tick();
    fu_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; fu_rdy = 1'b0; flush = 1'b0;
    cdb_tag = '0; cdb_valid = '0; instr = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_ready_in", 32'(ready_in), 32'd1);
    chk("rst_valid_out", 32'(valid_out), 32'd0);
    chk("rst_data_zero", 32'(data_out == '0), 32'd1);
    chk("rst_count", 32'(count), 32'd0);

    // Ready entry issues one edge after dispatch.
    dispatch(32'h100, 7'd10, 1'b1, 7'd11, 1'b1);
    chk("t1_valid", 32'(valid_out), 32'd1);
    chk("t1_pc", data_out.pc, 32'h100);
    chk("t1_count", 32'(count), 32'd1);
    sb.push_back(32'h100);
    drain(1);
    chk("t1_empty_valid", 32'(valid_out), 32'd0);
    chk("t1_empty_count", 32'(count), 32'd0);

    // Wakeup on highest CDB port.
    dispatch(32'h200, 7'd20, 1'b0, 7'd21, 1'b1);
    chk("t2_wait", 32'(valid_out), 32'd0);
    cdb_tag[CDB_PORTS-1] = 7'd20; cdb_valid = 3'b100;
    tick();
    cdb_valid = '0;
    chk("t2_woken", 32'(valid_out), 32'd1);
    chk("t2_pc", data_out.pc, 32'h200);
    sb.push_back(32'h200);
    drain(1);
    chk("t2_count", 32'(count), 32'd0);

    // Same-cycle dispatch forwarding from CDB.
    cdb_tag[0] = 7'd30; cdb_valid = 3'b001;
    dispatch(32'h300, 7'd30, 1'b0, 7'd31, 1'b1);
    cdb_valid = '0;
    chk("t3_valid", 32'(valid_out), 32'd1);
    chk("t3_ps1", 32'(data_out.ps1_ready), 32'd1);
    sb.push_back(32'h300);
    drain(1);

    // Older stalled entry vs younger ready entry.
    dispatch(32'hAAA, 7'd40, 1'b0, 7'd41, 1'b1);
    dispatch(32'hBBB, 7'd42, 1'b1, 7'd43, 1'b1);
`ifdef RS_OOO_ISSUE_EN
    chk("t4_bypass_valid", 32'(valid_out), 32'd1);
    chk("t4_bypass_pc", data_out.pc, 32'hBBB);
    sb.push_back(32'hBBB);
    drain(1);
    chk("t4_count1", 32'(count), 32'd1);
    chk("t4_a_wait", 32'(valid_out), 32'd0);
    cdb_tag[1] = 7'd40; cdb_valid = 3'b010;
    tick();
    cdb_valid = '0;
    chk("t4_a_pc", data_out.pc, 32'hAAA);
    sb.push_back(32'hAAA);
    drain(1);
`else
    chk("t4_inorder_stall", 32'(valid_out), 32'd0);
    drain(1);
    chk("t4_count2", 32'(count), 32'd2);
    cdb_tag[1] = 7'd40; cdb_valid = 3'b010;
    tick();
    cdb_valid = '0;
    chk("t4_a_pc", data_out.pc, 32'hAAA);
    sb.push_back(32'hAAA);
    sb.push_back(32'hBBB);
    drain(2);
`endif
    chk("t4_count0", 32'(count), 32'd0);

    // Fill to DEPTH, overflow dispatch ignored, one issue reopens.
    for (int i = 0; i < DEPTH; i++) dispatch(32'h500 + 32'(i), 7'd1, 1'b1, 7'd2, 1'b1);
    chk("t5_full_ready_in", 32'(ready_in), 32'd0);
    chk("t5_full_count", 32'(count), 32'(DEPTH));
    dispatch(32'h5FF, 7'd1, 1'b1, 7'd2, 1'b1);
    chk("t5_overflow_count", 32'(count), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) sb.push_back(32'h500 + 32'(i));
    drain(1);
    chk("t5_reopen_ready_in", 32'(ready_in), 32'd1);
    chk("t5_count", 32'(count), 32'(DEPTH - 1));
    drain(DEPTH - 1);
    chk("t5_drained", 32'(count), 32'd0);

    // Flush with simultaneous dispatch and issue.
    for (int i = 0; i < 5; i++) dispatch(32'h600 + 32'(i), 7'd1, 1'b1, 7'd2, 1'b1);
    chk("t6_fill", 32'(count), 32'd5);
    set_instr(32'h6FF, 7'd1, 1'b1, 7'd2, 1'b1);
    flush = 1'b1; valid_in = 1'b1; fu_rdy = 1'b1;
    tick();
    flush = 1'b0; valid_in = 1'b0; fu_rdy = 1'b0;
    chk("t6_flush_count", 32'(count), 32'd0);
    chk("t6_flush_valid", 32'(valid_out), 32'd0);
    chk("t6_flush_ready_in", 32'(ready_in), 32'd1);
    chk("t6_flush_data", 32'(data_out == '0), 32'd1);

    // Same using reset.
    for (int i = 0; i < 5; i++) dispatch(32'h700 + 32'(i), 7'd1, 1'b1, 7'd2, 1'b1);
    set_instr(32'h7FF, 7'd1, 1'b1, 7'd2, 1'b1);
    reset = 1'b1; valid_in = 1'b1; fu_rdy = 1'b1;
    tick();
    reset = 1'b0; valid_in = 1'b0; fu_rdy = 1'b0;
    chk("t6_reset_count", 32'(count), 32'd0);
    chk("t6_reset_valid", 32'(valid_out), 32'd0);
    chk("t6_reset_ready_in", 32'(ready_in), 32'd1);

    // Station still works after reset.
    dispatch(32'h800, 7'd5, 1'b1, 7'd6, 1'b1);
    chk("t7_pc", data_out.pc, 32'h800);
    sb.push_back(32'h800);
    drain(1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rs_ooo_generic.md
# rs_ooo_generic

Parametrised reservation station, successor to the fixed-depth in-order branch station. Buffers renamed micro-ops from dispatch, snoops a configurable number of CDB wakeup ports, and issues one ready entry per cycle to its functional unit. Age order is kept in a collapsing queue. With out-of-order select compiled in, the oldest ready entry issues rather than only the head. One instance sits per FU class, between dispatch and execute.

## Interface
Parameters:
- DEPTH, 8 — number of entries; ≥2.
- CDB_PORTS, 3 — number of CDB wakeup ports; ≥1.
- PREG_W, 7 — physical register tag width; must match types_pkg.

Ports:
- clk  in  1  clock; sole clock domain.
- reset  in  1  synchronous, active-high reset.
- valid_in  in  1  dispatch request.
- instr  in  dispatch_pipeline_data  micro-op fields: pc, Opcode, prd, pr1, pr1_ready, pr2, pr2_ready, rob_index, imm, func3, func7.
- ready_in  out  1  station can accept an entry this cycle.
- fu_rdy  in  1  FU accepts an issue this cycle.
- valid_out  out  1  data_out holds an issuable entry.
- data_out  out  rs_data  selected entry, including ps1_ready/ps2_ready.
- cdb_tag  in  [CDB_PORTS][PREG_W]  broadcast physical tags.
- cdb_valid  in  CDB_PORTS  per-port broadcast valid.
- flush  in  1  discard every entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Storage: slots 0..DEPTH-1. Slot 0 is always the oldest entry. Slots 0..count-1 are valid; there are no holes.
- Dispatch happens when valid_in && ready_in. The entry is written at slot count, or at slot count-1 if an issue removes an entry the same cycle. Dispatch with ready_in=0 is ignored (no write, no error).
- Dispatch forwarding: an operand's stored ready bit = prN_ready OR (prN matches any cdb_tag[k] with cdb_valid[k]) in the same cycle.
- Wakeup: every valid entry compares pr1 and pr2 against all valid CDB ports each cycle. A match sets the ready bit at the next edge. Ready bits never clear.
- Entry ready = ps1_ready && ps2_ready.
- Select: the lowest-index ready slot, or slot 0 only (see Configuration). valid_out = a selected slot exists. data_out = that slot, or all-zero when valid_out=0.
- Issue happens when valid_out && fu_rdy. The selected slot is removed, and all slots above it shift down by one in the same edge. Wakeups seen that cycle are applied to the shifted entries.
- ready_in = (count < DEPTH), taken from registered count only. No full-with-issue bypass.
- count updates as count + dispatch − issue.
- Flush takes priority over dispatch, issue and wakeup in its cycle. All slots are invalidated and count=0. The FU must ignore any valid_out/data_out present during the flush cycle.
- Reset behaves like flush and wins over everything. Reset mid-operation drops all entries.

## Timing
- Reset values: ready_in=1, valid_out=0, data_out=0, count=0. All slot valid and ready bits are 0.
- Dispatch→issuable latency: 1 edge. An entry dispatched ready at edge N gives valid_out=1 right after edge N, from combinational select on registered state.
- CDB→issuable latency: 1 edge. A broadcast before edge N makes the entry visible as ready after edge N.
- Issue: data_out is consumed at the edge where valid_out && fu_rdy. The next selection is visible after that edge, which gives a throughput of 1 issue/cycle.
- Full: after the DEPTH-th accepted dispatch, ready_in=0 until the edge after the first issue or a flush.
- Empty: valid_out=0. An issue attempt with fu_rdy=1 has no effect.
- Simultaneous dispatch + issue when count=DEPTH: not possible, because ready_in=0.
- Simultaneous dispatch + issue when 0<count<DEPTH: count stays unchanged and order is preserved. The new entry is youngest.

## Configuration
- RS_OOO_ISSUE_EN defined: select the oldest ready slot in the whole queue. A younger ready entry bypasses a stalled older one.
- RS_OOO_ISSUE_EN undefined: select considers slot 0 only, giving strict in-order issue. Logic is removed except the slot-0 path and shift-by-one-from-slot-0. Removal then always happens at slot 0.

## Test plan
- Reset, then dispatch pc=0x100 with pr1=10/pr2=11 both ready → valid_out=1 and data_out.pc=0x100 after 1 edge. With fu_rdy=1 for 1 edge → valid_out=0, count=0.
- Dispatch pc=0x200 with pr1=20 not ready, then broadcast tag 20 on cdb port 2 (CDB_PORTS-1) → valid_out=0 before the broadcast. valid_out=1 with pc=0x200 one edge after the broadcast.
- Dispatch pr1=30 not ready, with cdb_tag[0]=30 valid in the same cycle → after the edge, valid_out=1 and data_out.ps1_ready=1.
- Dispatch A (0xAAA, waits on P40) then B (0xBBB, ready). With RS_OOO_ISSUE_EN: issue B first, count=1, and A is issued after P40 is broadcast. Without the macro: valid_out=0 until P40 is broadcast, then A issues before B.
- Dispatch DEPTH ready entries (pc 0x500+i) with fu_rdy=0 → ready_in=0 and count=DEPTH. A 9th valid_in is ignored. One issue → pc=0x500 issues and ready_in=1 after that edge.
- Fill with 5 entries, then assert flush together with valid_in and fu_rdy for 1 edge → count=0, valid_out=0, ready_in=1, and no entry written. Repeat using reset instead of flush → same result.
